// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - multi-outstanding instruction fetch stage with instruction queue
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1C000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_allow_in,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_ex_adef
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW  = $clog2(IBUF_DEPTH + 1);
    localparam int RW  = CW + 1;
    localparam int PPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int IPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    logic [31:0]    fetch_pc;
    logic [31:0]    pend_pc [MAX_OUTSTANDING];
    logic [PPW-1:0] pend_wr;
    logic [PPW-1:0] pend_rd;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  discard;
    logic [31:0]    ib_pc   [IBUF_DEPTH];
    logic [31:0]    ib_inst [IBUF_DEPTH];
    logic           ib_adef [IBUF_DEPTH];
    logic [IPW-1:0] ib_wr;
    logic [IPW-1:0] ib_rd;
    logic [CW-1:0]  ib_count;
    logic           adef_hold;

    logic           redirect;
    logic [31:0]    redirect_pc;
    logic           misaligned;
    logic [RW-1:0]  reserved;
    logic           has_room;
    logic           fire;
    logic           resp;
    logic           resp_keep;
    logic           adef_push;
    logic           ib_push;
    logic           ib_pop;
    logic [31:0]    push_pc;
    logic [31:0]    push_inst;

    function automatic logic [PPW-1:0] pend_inc(input logic [PPW-1:0] p);
        pend_inc = (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IPW-1:0] ib_inc(input logic [IPW-1:0] p);
        ib_inc = (32'(p) == IBUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign redirect    = flush_valid | (br_taken & ~br_stall);
    assign redirect_pc = flush_valid ? flush_pc : br_target;
    assign misaligned  = fetch_pc[1:0] != 2'b00;

    // Queue slots are reserved at issue time; stale in-flight requests hold no slot.
    assign reserved = RW'(ib_count) + RW'(outstanding) - RW'(discard);
    assign has_room = reserved < RW'(IBUF_DEPTH);

    assign inst_sram_req = ~reset & ~redirect & ~br_stall & ~adef_hold & ~misaligned
                         & (outstanding < OW'(MAX_OUTSTANDING)) & has_room;
    assign fire      = inst_sram_req & inst_sram_addr_ok;
    assign resp      = inst_sram_data_ok & (outstanding != '0);
    assign resp_keep = resp & (discard == '0) & ~redirect;
    assign adef_push = misaligned & ~adef_hold & ~redirect & has_room & ~resp_keep;
    assign ib_push   = resp_keep | adef_push;
    assign push_pc   = resp_keep ? pend_pc[pend_rd] : fetch_pc;
    assign push_inst = resp_keep ? inst_sram_rdata : 32'h0;

    assign fs_to_ds_valid = (ib_count != '0) & ~redirect;
    assign ib_pop         = fs_to_ds_valid & ds_allow_in;
    assign fs_pc          = ib_pc[ib_rd];
    assign fs_inst        = ib_inst[ib_rd];
    assign fs_ex_adef     = ib_adef[ib_rd];

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            pend_wr     <= '0;
            pend_rd     <= '0;
            outstanding <= '0;
            discard     <= '0;
            ib_wr       <= '0;
            ib_rd       <= '0;
            ib_count    <= '0;
            adef_hold   <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pend_pc[i] <= 32'h0;
            end
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ib_pc[i]   <= 32'h0;
                ib_inst[i] <= 32'h0;
                ib_adef[i] <= 1'b0;
            end
        end else begin
            if (resp) begin
                pend_rd <= pend_inc(pend_rd);
            end
            if (fire) begin
                pend_pc[pend_wr] <= fetch_pc;
                pend_wr          <= pend_inc(pend_wr);
            end
            outstanding <= outstanding + OW'(fire) - OW'(resp);

            if (redirect) begin
                // Everything still in flight after this cycle's response becomes stale.
                fetch_pc  <= redirect_pc;
                adef_hold <= 1'b0;
                discard   <= outstanding - OW'(resp);
                ib_wr     <= '0;
                ib_rd     <= '0;
                ib_count  <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (adef_push) begin
                    adef_hold <= 1'b1;
                end
                if (resp && discard != '0) begin
                    discard <= discard - 1'b1;
                end
                if (ib_push) begin
                    ib_pc[ib_wr]   <= push_pc;
                    ib_inst[ib_wr] <= push_inst;
                    ib_adef[ib_wr] <= ~resp_keep;
                    ib_wr          <= ib_inc(ib_wr);
                end
                if (ib_pop) begin
                    ib_rd <= ib_inc(ib_rd);
                end
                ib_count <= ib_count + CW'(ib_push) - CW'(ib_pop);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed vector and sequence bench for if_fetch_queue
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_ex_adef;

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk(clk), .reset(reset),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .br_stall(br_stall), .br_taken(br_taken), .br_target(br_target),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .ds_allow_in(ds_allow_in), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_ex_adef(fs_ex_adef)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk32(name, {31'h0, act}, {31'h0, req});
    endtask

    typedef struct {
        logic        rst;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        ds;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic        e_head;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adef;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic aok, input logic dok,
                                input logic [31:0] rd, input logic ds, input logic e_req,
                                input logic [31:0] e_addr, input logic e_val, input logic e_head,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_adef);
        vec_t v;
        v.rst = rst; v.aok = aok; v.dok = dok; v.rd = rd; v.ds = ds;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_head = e_head;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_adef = e_adef;
        return v;
    endfunction

    // Bus model: accepted addresses return in order one cycle later with data ~addr.
    logic [31:0] pend_q[$];
    logic [31:0] exp_pc;
    bit          sb_en;
    bit          bus_accept;
    bit          bus_hold;
    int          recv, acc, req_seen, valid_seen;
    logic        last_req, last_valid, last_adef;
    logic [31:0] last_addr, last_pc, last_inst;

    task automatic tick();
        @(negedge clk);
        inst_sram_addr_ok = bus_accept;
        inst_sram_data_ok = !bus_hold && pend_q.size() > 0;
        inst_sram_rdata   = inst_sram_data_ok ? ~pend_q[0] : 32'h0;
        #1;
        last_req   = inst_sram_req;
        last_addr  = inst_sram_addr;
        last_valid = fs_to_ds_valid;
        last_pc    = fs_pc;
        last_inst  = fs_inst;
        last_adef  = fs_ex_adef;
        if (sb_en && fs_to_ds_valid && ds_allow_in) begin
            chk32("sb_pc", fs_pc, exp_pc);
            chk32("sb_inst", fs_inst, ~exp_pc);
            chk1("sb_adef", fs_ex_adef, 1'b0);
            exp_pc = exp_pc + 32'd4;
            recv++;
        end
        if (fs_to_ds_valid) valid_seen++;
        if (inst_sram_req) req_seen++;
        if (inst_sram_req && inst_sram_addr_ok) begin
            pend_q.push_back(inst_sram_addr);
            acc++;
        end
        if (inst_sram_data_ok) void'(pend_q.pop_front());
        if (reset) pend_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_valid = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
        bus_accept = 1'b0; bus_hold = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        pend_q.delete();
        recv = 0; acc = 0; req_seen = 0; valid_seen = 0;
    endtask

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush_valid = 1'b0; flush_pc = 32'h0;
        br_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        ds_allow_in = 1'b1;
        sb_en = 1'b0; bus_accept = 1'b0; bus_hold = 1'b0;
        recv = 0; acc = 0; req_seen = 0; valid_seen = 0; exp_pc = 32'h0;

        vt[0] = mk(1, 0, 0, 32'h0,        1, 0, 32'h1C000000, 0, 1, 32'h0, 32'h0, 0);
        vt[1] = mk(0, 1, 0, 32'h0,        1, 1, 32'h1C000000, 0, 0, 32'h0, 32'h0, 0);
        vt[2] = mk(0, 1, 1, 32'hE3FFFFFF, 1, 1, 32'h1C000004, 0, 0, 32'h0, 32'h0, 0);
        vt[3] = mk(0, 1, 1, 32'hE3FFFFFB, 1, 1, 32'h1C000008, 1, 1, 32'h1C000000, 32'hE3FFFFFF, 0);
        vt[4] = mk(0, 1, 1, 32'hE3FFFFF7, 1, 1, 32'h1C00000C, 1, 1, 32'h1C000004, 32'hE3FFFFFB, 0);
        vt[5] = mk(0, 0, 1, 32'hE3FFFFF3, 1, 1, 32'h1C000010, 1, 1, 32'h1C000008, 32'hE3FFFFF7, 0);
        vt[6] = mk(0, 0, 0, 32'h0,        1, 1, 32'h1C000010, 1, 1, 32'h1C00000C, 32'hE3FFFFF3, 0);
        vt[7] = mk(0, 0, 0, 32'h0,        1, 1, 32'h1C000010, 0, 0, 32'h0, 32'h0, 0);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset             = vt[i].rst;
            inst_sram_addr_ok = vt[i].aok;
            inst_sram_data_ok = vt[i].dok;
            inst_sram_rdata   = vt[i].rd;
            ds_allow_in       = vt[i].ds;
            #1;
            chk1($sformatf("v%0d_req", i), inst_sram_req, vt[i].e_req);
            chk32($sformatf("v%0d_addr", i), inst_sram_addr, vt[i].e_addr);
            chk1($sformatf("v%0d_valid", i), fs_to_ds_valid, vt[i].e_val);
            if (vt[i].e_head) begin
                chk32($sformatf("v%0d_pc", i), fs_pc, vt[i].e_pc);
                chk32($sformatf("v%0d_inst", i), fs_inst, vt[i].e_inst);
                chk1($sformatf("v%0d_adef", i), fs_ex_adef, vt[i].e_adef);
            end
        end
        chk32("const_side", {inst_sram_wr, inst_sram_size, inst_sram_wstrb}, {25'h0, 7'b0100000});
        chk32("const_wdata", inst_sram_wdata, 32'h0);

        // ID back-pressure: four slots fill, then drain in order
        do_reset();
        ds_allow_in = 1'b0; bus_accept = 1'b1; sb_en = 1'b1; exp_pc = 32'h1C000000;
        repeat (10) tick();
        chk32("bp_issued", acc, 32'd4);
        chk1("bp_req_low", last_req, 1'b0);
        chk1("bp_head_valid", last_valid, 1'b1);
        ds_allow_in = 1'b1;
        repeat (10) tick();
        chk1("bp_drain", recv >= 4, 1'b1);

        // Flush with two outstanding: both late responses dropped
        do_reset();
        ds_allow_in = 1'b1; bus_accept = 1'b1; bus_hold = 1'b1; exp_pc = 32'h1C000000;
        repeat (3) tick();
        chk32("fl_outstanding", pend_q.size(), 32'd2);
        chk1("fl_req_full", last_req, 1'b0);
        flush_valid = 1'b1; flush_pc = 32'h1C000100;
        tick();
        chk1("fl_req_redirect", last_req, 1'b0);
        flush_valid = 1'b0; bus_hold = 1'b0; exp_pc = 32'h1C000100; recv = 0;
        repeat (10) tick();
        chk1("fl_recv", recv >= 1, 1'b1);

        // br_stall blocks issue; branch in the same cycle as a response
        do_reset();
        bus_accept = 1'b1; bus_hold = 1'b1; exp_pc = 32'h1C000000;
        br_stall = 1'b1;
        tick();
        chk1("bs_req_stall", last_req, 1'b0);
        br_stall = 1'b0;
        repeat (3) tick();
        chk32("br_outstanding", pend_q.size(), 32'd2);
        br_taken = 1'b1; br_target = 32'h1C000040; bus_hold = 1'b0; exp_pc = 32'h1C000040;
        tick();
        chk1("br_req_redirect", last_req, 1'b0);
        chk1("br_valid_redirect", last_valid, 1'b0);
        br_taken = 1'b0; recv = 0;
        repeat (10) tick();
        chk1("br_recv", recv >= 1, 1'b1);

        // Misaligned branch target: one ADEF entry, fetch halted until flush
        do_reset();
        bus_accept = 1'b1; sb_en = 1'b0; ds_allow_in = 1'b0;
        br_taken = 1'b1; br_target = 32'h1C000042;
        tick();
        br_taken = 1'b0; req_seen = 0;
        repeat (4) tick();
        chk32("adef_no_req", req_seen, 32'd0);
        chk1("adef_valid", last_valid, 1'b1);
        chk32("adef_pc", last_pc, 32'h1C000042);
        chk32("adef_inst", last_inst, 32'h0);
        chk1("adef_flag", last_adef, 1'b1);
        ds_allow_in = 1'b1;
        tick();
        valid_seen = 0; req_seen = 0;
        repeat (4) tick();
        chk32("adef_single", valid_seen, 32'd0);
        chk32("adef_hold_req", req_seen, 32'd0);
        flush_valid = 1'b1; flush_pc = 32'h1C008000;
        tick();
        flush_valid = 1'b0; sb_en = 1'b1; exp_pc = 32'h1C008000; recv = 0;
        repeat (8) tick();
        chk1("adef_restart", recv >= 1, 1'b1);

        // Flush beats branch; reset with requests outstanding
        do_reset();
        sb_en = 1'b0; bus_accept = 1'b1; bus_hold = 1'b1;
        flush_valid = 1'b1; flush_pc = 32'h1C000200;
        br_taken = 1'b1; br_target = 32'h1C000300;
        tick();
        flush_valid = 1'b0; br_taken = 1'b0;
        tick();
        chk1("prio_req", last_req, 1'b1);
        chk32("prio_addr", last_addr, 32'h1C000200);
        tick();
        chk32("rst_outstanding", pend_q.size(), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0; bus_accept = 1'b0; bus_hold = 1'b0; ds_allow_in = 1'b0; valid_seen = 0;
        repeat (5) tick();
        chk32("rst_no_valid", valid_seen, 32'd0);
        chk1("rst_req", last_req, 1'b1);
        chk32("rst_addr", last_addr, 32'h1C000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage for the LoongArch pipeline, sitting between the branch/exception redirect sources and the ID stage, driving the SRAM-like inst_sram interface (req/addr_ok/data_ok). Unlike the single-request IF stage, it keeps up to MAX_OUTSTANDING fetches in flight. It buffers returned instructions in an IBUF_DEPTH-entry queue, so ID back-pressure never stalls the bus. Stale responses after any redirect are discarded with a counter, not a one-shot flag.

## Interface
- RESET_PC, 32'h1C000000, first fetch address after reset
- MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (1..8)
- IBUF_DEPTH, 4, instruction queue entries (power of 2, >= MAX_OUTSTANDING)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush_valid  in  1  exception/ertn redirect from WB (highest priority)
- flush_pc  in  32  target for flush (ex_entry or ertn_pc, muxed by WB)
- br_stall  in  1  ID still resolving a branch; blocks new requests
- br_taken  in  1  branch redirect, valid only when br_stall=0
- br_target  in  32  branch target
- inst_sram_req  out  1  request
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  equals fetch_pc
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  response valid (in request order)
- inst_sram_rdata  in  32  response data
- ds_allow_in  in  1  ID can accept
- fs_to_ds_valid  out  1  queue head valid to ID
- fs_pc  out  32  head PC
- fs_inst  out  32  head instruction (0 for ADEF entry)
- fs_ex_adef  out  1  head carries fetch-address exception

## Operation
- redirect = flush_valid | (br_taken & ~br_stall); redirect_pc = flush_valid ? flush_pc : br_target.
- State: fetch_pc; pending-PC FIFO (depth MAX_OUTSTANDING); outstanding count; discard count; ibuf (pc, inst, adef) with count; adef_hold flag.
- inst_sram_req = ~reset & ~redirect & ~br_stall & ~adef_hold & fetch_pc[1:0]==0 & outstanding<MAX_OUTSTANDING & (ibuf_count + outstanding - discard) < IBUF_DEPTH. The slot is reserved at issue time, so a response always has room.
- Handshake (req & addr_ok): push fetch_pc to pending FIFO, outstanding+1, fetch_pc <= fetch_pc+4.
- data_ok: pop pending FIFO, outstanding-1. If discard>0, discard-1 and drop the data. Otherwise, if no redirect this cycle, write {pc, rdata, 0} to ibuf.
- Misaligned fetch_pc with ~adef_hold and ~redirect: push {fetch_pc, 0, 1} to ibuf when there is space, set adef_hold. No bus request is made. Fetch stays stopped until the next redirect.
- Redirect cycle:
  - fetch_pc <= redirect_pc
  - ibuf cleared
  - adef_hold cleared
  - discard <= outstanding after this cycle's data_ok pop, so every in-flight request becomes stale
  - flush wins over branch when both are asserted
- fs_to_ds_valid = ibuf_nonempty & ~redirect. Pop when fs_to_ds_valid & ds_allow_in. A push and a pop in the same cycle are both allowed; count is unchanged.
- Invariants: discard <= outstanding <= MAX_OUTSTANDING; ibuf_count <= IBUF_DEPTH.

## Timing
- Reset values: req=0 during reset; fetch_pc=RESET_PC; all counts 0; adef_hold=0; fs_to_ds_valid=0; fs_pc/fs_inst/fs_ex_adef=0.
- First req is asserted the cycle after reset deasserts, with addr=RESET_PC.
- inst_sram_addr is stable while req=1 and addr_ok=0. It changes only after a handshake or a redirect; req is low in the redirect cycle.
- Latency: a data_ok at cycle N makes the entry visible on fs_to_ds_valid at N+1 (registered queue). There is no combinational path from rdata to fs_inst.
- Back-to-back issue: with addr_ok held at 1, one request per cycle is issued until the outstanding or ibuf limit is reached.
- Widths: counters are $clog2(MAX+1) and $clog2(DEPTH+1) bits; pointers wrap modulo depth; fetch_pc+4 wraps modulo 2^32.

## Test plan
- Reset, then addr_ok and data_ok each with 1-cycle latency, ds_allow_in=1 -> ID receives PCs 1C000000, 1C000004, 1C000008 in order, one per cycle in steady state.
- ds_allow_in=0 for 10 cycles (IBUF_DEPTH=4, MAX_OUTSTANDING=2) -> req drops once 4 slots are reserved. Then release -> 4 entries drain in order with no loss or duplication.
- Two requests outstanding, then flush_valid with flush_pc=1C000100 -> the two late data_ok responses are dropped (discard goes 2->1->0), and the next ID instruction has PC 1C000100.
- br_taken with br_target=1C000040 in the same cycle as data_ok, one other request still outstanding -> the current and remaining response are both dropped, and the first valid fs_pc is 1C000040.
- br_target=1C000042 -> no inst_sram_req. A single ID entry appears with fs_ex_adef=1, fs_pc=1C000042, fs_inst=0. Fetch holds until flush_pc=1C008000 restarts it.
- Flush and branch asserted together -> flush_pc wins; reset asserted with 2 outstanding -> all counts 0 and no fs_to_ds_valid afterwards.
